// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: round-robin sharing of one frame transmitter among NUM_REQ sources,
// with latched header fields, done/timeout handling and an inter-frame gap.
module frame_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*48-1:0]   req_dest_addr,
    input  logic [NUM_REQ*48-1:0]   req_src_addr,
    input  logic [NUM_REQ*16-1:0]   req_eth_type,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_err,
    output logic                    tx_start,
    output logic [47:0]             tx_dest_addr,
    output logic [47:0]             tx_src_addr,
    output logic [15:0]             tx_eth_type,
    output logic [31:0]             tx_data,
    input  logic                    tx_done,
    output logic                    busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, IFG} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        ptr, ptr_n, win;
    logic [TW-1:0]        wcnt, wcnt_n;
    logic [IW-1:0]        icnt, icnt_n;
    logic [NUM_REQ-1:0]   gnt_n, done_n, err_n;
    logic                 start_n;
    logic [47:0]          dest_n, src_n;
    logic [15:0]          type_n;
    logic [31:0]          data_n;
    logic [47:0]          dst [NUM_REQ];
    logic [47:0]          src [NUM_REQ];
    logic [15:0]          typ [NUM_REQ];
    logic [31:0]          dat [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign dst[i] = req_dest_addr[48*i +: 48];
        assign src[i] = req_src_addr[48*i +: 48];
        assign typ[i] = req_eth_type[16*i +: 16];
        assign dat[i] = req_data[32*i +: 32];
    end

    // Lowest set bit overall covers the wrap case; lowest set bit at/above ptr overrides it.
    always_comb begin
        win = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) win = PW'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i] && PW'(i) >= ptr) win = PW'(i);
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        wcnt_n  = wcnt;
        icnt_n  = icnt;
        gnt_n   = gnt;
        done_n  = '0;
        err_n   = '0;
        start_n = 1'b0;
        dest_n  = tx_dest_addr;
        src_n   = tx_src_addr;
        type_n  = tx_eth_type;
        data_n  = tx_data;
        case (state)
            IDLE: if (|req) begin
                state_n = START;
                gnt_n   = NUM_REQ'(1) << win;
                ptr_n   = win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
                start_n = 1'b1;
                dest_n  = dst[win];
                src_n   = src[win];
                type_n  = typ[win];
                data_n  = dat[win];
            end
            START: begin
                state_n = WAIT_DONE;
                wcnt_n  = '0;
            end
            WAIT_DONE: begin
                // tx_done takes priority over a timeout landing in the same cycle
                if (tx_done || wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    done_n  = tx_done ? gnt : '0;
                    err_n   = tx_done ? '0 : gnt;
                    gnt_n   = '0;
                    icnt_n  = '0;
                    state_n = IFG;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            IFG: begin
                state_n = icnt == IW'(IFG_CYCLES) ? IDLE : IFG;
                icnt_n  = icnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            wcnt         <= '0;
            icnt         <= '0;
            gnt          <= '0;
            req_done     <= '0;
            req_err      <= '0;
            tx_start     <= 1'b0;
            tx_dest_addr <= '0;
            tx_src_addr  <= '0;
            tx_eth_type  <= '0;
            tx_data      <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            wcnt         <= wcnt_n;
            icnt         <= icnt_n;
            gnt          <= gnt_n;
            req_done     <= done_n;
            req_err      <= err_n;
            tx_start     <= start_n;
            tx_dest_addr <= dest_n;
            tx_src_addr  <= src_n;
            tx_eth_type  <= type_n;
            tx_data      <= data_n;
            busy         <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: randomized frames against a transaction-level round-robin model;
// expected start/done/err events are queued and checked by an independent monitor.
module tb_frame_tx_scheduler;
    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int TO  = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*48-1:0]  req_dest_addr, req_src_addr;
    logic [N*16-1:0]  req_eth_type;
    logic [N*32-1:0]  req_data;
    logic [N-1:0]     gnt, req_done, req_err;
    logic             tx_start, tx_done = 1'b0, busy;
    logic [47:0]      tx_dest_addr, tx_src_addr;
    logic [15:0]      tx_eth_type;
    logic [31:0]      tx_data;

    logic [47:0] dst [N];
    logic [47:0] src [N];
    logic [15:0] typ [N];
    logic [31:0] dat [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_dest_addr[48*g +: 48] = dst[g];
        assign req_src_addr[48*g +: 48]  = src[g];
        assign req_eth_type[16*g +: 16]  = typ[g];
        assign req_data[32*g +: 32]      = dat[g];
    end

    frame_tx_scheduler #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_dest_addr(req_dest_addr), .req_src_addr(req_src_addr),
        .req_eth_type(req_eth_type), .req_data(req_data),
        .gnt(gnt), .req_done(req_done), .req_err(req_err), .tx_start(tx_start),
        .tx_dest_addr(tx_dest_addr), .tx_src_addr(tx_src_addr),
        .tx_eth_type(tx_eth_type), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 start, 1 done, 2 err
        logic [3:0]  mask;
        logic [47:0] dst, src;
        logic [15:0] typ;
        logic [31:0] dat;
        int          at;
    } item_t;

    item_t exp_q[$];
    item_t cur, got;
    bit    active = 0;
    int    compared = 0, mismatched = 0;
    int    ptr_m = 0, idle_at = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) active = 0;
        else if (tx_start || |req_done || |req_err) begin
            if (exp_q.size() == 0) chk("unexpected_event_queue", 64'(exp_q.size()), 64'd1);
            else begin
                got = exp_q.pop_front();
                chk("event_kind", 64'(tx_start ? 0 : (|req_done ? 1 : 2)), 64'(got.kind));
                chk("event_cycle", 64'(cyc), 64'(got.at));
                if (got.kind == 0) begin
                    chk("start_gnt", 64'(gnt), 64'(got.mask));
                    chk("start_dest", 64'(tx_dest_addr), 64'(got.dst));
                    chk("start_src", 64'(tx_src_addr), 64'(got.src));
                    chk("start_type", 64'(tx_eth_type), 64'(got.typ));
                    chk("start_data", 64'(tx_data), 64'(got.dat));
                    chk("start_busy", 64'(busy), 64'd1);
                    cur = got;
                    active = 1;
                end else begin
                    chk("end_mask", 64'(got.kind == 1 ? req_done : req_err), 64'(got.mask));
                    chk("end_other_pulse", 64'(got.kind == 1 ? req_err : req_done), 64'd0);
                    chk("end_gnt", 64'(gnt), 64'd0);
                    active = 0;
                end
            end
        end else if (active) begin
            chk("hold_gnt", 64'(gnt), 64'(cur.mask));
            chk("hold_fields", {tx_dest_addr, tx_eth_type}, {cur.dst, cur.typ});
            chk("hold_src_data", {tx_src_addr[31:0], tx_data}, {cur.src[31:0], cur.dat});
            chk("hold_busy", 64'(busy), 64'd1);
        end
    end

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            dst[i] = 48'({$urandom, $urandom});
            src[i] = 48'({$urandom, $urandom});
            typ[i] = 16'($urandom);
            dat[i] = $urandom;
        end
    endtask

    // Present a request mask and return the cycle its tx_start must appear.
    task automatic issue(input logic [3:0] mask, input bit fixed, output int st, output item_t s);
        int w;
        randomize_fields();
        if (fixed) begin
            dst[0] = 48'h123456789ABC;
            src[0] = 48'hABCDEF123456;
            typ[0] = 16'h0800;
            dat[0] = 32'hDEADBEEF;
        end
        w = 0;
        for (int k = N - 1; k >= 0; k--)
            if (((mask >> ((ptr_m + k) % N)) & 4'd1) != 0) w = (ptr_m + k) % N;
        s.kind = 0;
        s.mask = 4'(1 << w);
        s.dst  = dst[w];
        s.src  = src[w];
        s.typ  = typ[w];
        s.dat  = dat[w];
        s.at   = (cyc > idle_at ? cyc : idle_at) + 1;
        exp_q.push_back(s);
        req   = mask;
        ptr_m = (w + 1) % N;
        st    = s.at;
        while (cyc < st) tick();
    endtask

    // r = cycles after tx_start at which tx_done is driven; 1..TO completes, else times out.
    task automatic xact(input logic [3:0] mask, input int r, input bit drop, input bit spur, input bit fixed);
        item_t s, f;
        int st, x, p, endl;
        bit ok;
        issue(mask, fixed, st, s);
        x  = st + r;
        ok = r >= 1 && r <= TO;
        p  = ok ? x + 1 : st + TO + 1;
        f      = s;
        f.kind = ok ? 1 : 2;
        f.at   = p;
        exp_q.push_back(f);
        endl = (x > p + 3 ? x : p + 3) + 1;
        for (int l = st; l <= endl; l++) begin
            tx_done = (l == x) || (spur && (l == st || l == p + 3));
            if (l == st) begin
                randomize_fields();
                if (drop) req = '0;
            end
            if (l == p) req = '0;
            tick();
        end
        idle_at = p + IFG + 1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    initial begin
        item_t s;
        int st, pick, r;
        randomize_fields();
        repeat (3) tick();
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_pulses", 64'({req_done, req_err, tx_start}), 64'd0);
        chk("reset_fields", {tx_dest_addr, tx_eth_type}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n   = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("idle_spurious_busy", 64'(busy), 64'd0);
        idle_at = cyc;

        xact(4'b0001, 20, 0, 0, 1);
        for (int i = 0; i < 5; i++) xact(4'b1111, 5, 0, 0, 0);
        xact(4'b1000, 7, 0, 1, 0);
        xact(4'b1001, 3, 1, 0, 0);
        xact(4'b1001, 9, 0, 0, 0);
        xact(4'b0100, TO + 3, 0, 0, 0);
        xact(4'b0010, TO, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            pick = $urandom_range(0, 9);
            r = pick == 0 ? TO : pick == 1 ? TO + $urandom_range(1, 8) : pick == 2 ? 0 : $urandom_range(1, 30);
            gap($urandom_range(0, 16));
            xact(4'($urandom_range(1, 15)), r, 1'($urandom), 1'($urandom), 0);
        end

        gap(3);
        issue(4'b0110, 0, st, s);
        gap(5);
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
        chk("midreset_gnt", 64'(gnt), 64'd0);
        chk("midreset_pulses", 64'({req_done, req_err, tx_start}), 64'd0);
        chk("midreset_fields", {tx_src_addr, tx_data[15:0]}, 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        ptr_m   = 0;
        idle_at = cyc;
        xact(4'b1111, 4, 0, 0, 0);
        xact(4'b1111, 4, 0, 0, 0);

        gap(20);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/frame_tx_scheduler.md
Name: frame_tx_scheduler

Overview:
Round-robin arbiter and sequencer that shares one frame_transmission datapath among NUM_REQ frame sources. It selects a requester, latches its header/payload fields, pulses start to the transmitter, waits for tx_done (with a watchdog), and enforces an inter-frame gap before the next grant. It sits between the per-port frame sources and the frame_transmission block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IFG_CYCLES, 12, idle clocks between tx_done and the next grant (>=1)
TIMEOUT_CYCLES, 1024, max clocks in WAIT_DONE before abort (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester frame request, level, held until req_done/req_err
req_dest_addr  in  NUM_REQ*48  dest addr, requester i at [48i+47:48i]
req_src_addr  in  NUM_REQ*48  src addr, same packing
req_eth_type  in  NUM_REQ*16  EtherType, same packing
req_data  in  NUM_REQ*32  payload word, same packing
gnt  out  NUM_REQ  one-hot grant, high from START through end of WAIT_DONE
req_done  out  NUM_REQ  one-hot 1-cycle pulse: granted frame completed
req_err  out  NUM_REQ  one-hot 1-cycle pulse: granted frame timed out
tx_start  out  1  1-cycle start pulse to frame_transmission
tx_dest_addr  out  48  latched fields to frame_transmission, stable START..WAIT_DONE
tx_src_addr  out  48  as above
tx_eth_type  out  16  as above
tx_data  out  32  as above
tx_done  in  1  completion from frame_transmission
busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock domain; all outputs registered; reset synchronous active-low on rising clk.
- Reset: state=IDLE, gnt=0, req_done=0, req_err=0, tx_start=0, tx_* fields=0, busy=0, rr pointer=0, counters=0. Reset mid-frame aborts immediately; no done/err pulse issued.
- States: IDLE, START, WAIT_DONE, IFG.
- IDLE: if |req, pick first set bit searching from rr pointer upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...). Next cycle: state=START, gnt=one-hot winner, tx_* fields latched from winner's slice, tx_start=1, rr pointer=(winner+1) mod NUM_REQ. No req: stay IDLE.
- START: exactly one cycle; tx_start=1 only here. -> WAIT_DONE, timeout counter cleared.
- WAIT_DONE: tx_done=1 -> next cycle req_done[winner]=1 for one cycle, gnt=0, state=IFG. Else counter increments; when counter reaches TIMEOUT_CYCLES-1 with no tx_done -> req_err[winner]=1 one cycle, gnt=0, state=IFG. tx_done and timeout in same cycle: tx_done wins (done, not err).
- tx_done while in IDLE, START or IFG is ignored (stale/spurious).
- IFG: counts IFG_CYCLES clocks, then IDLE; arbitration occurs in IDLE, so grant-to-grant minimum gap = IFG_CYCLES+1 idle clocks after the done pulse cycle.
- Latency: req rising in IDLE -> tx_start 1 cycle later.
- Requester dropping req after grant does not abort the frame; completion still pulses req_done. Fields changing after grant have no effect (latched).
- Requester still holding req after its done re-competes normally; round-robin guarantees others are served first.
- busy=1 in START, WAIT_DONE, IFG.

Test Plan:
- Single request: reset, req=4'b0001, dest=48'h123456789ABC, src=48'hABCDEF123456, type=16'h0800, data=32'hDEADBEEF; tx_done asserted 20 cycles after tx_start -> tx_start one cycle, 1 cycle after req; fields match; gnt=0001 until done; req_done=0001 pulse; next grant impossible for 13 cycles.
- Round-robin fairness: req=4'b1111 held, tx_done 5 cycles after each start -> grant order 0001,0010,0100,1000,0001; each start separated by >= IFG_CYCLES+1 idle cycles.
- Pointer wrap: after grant to requester 3, req=4'b1001 -> requester 0 granted next, then 3.
- Timeout: grant requester 2, never assert tx_done -> req_err=0100 exactly TIMEOUT_CYCLES cycles into WAIT_DONE, no req_done, then IFG and IDLE.
- Spurious/overlap: pulse tx_done in IDLE and in IFG -> no state change, no pulses; tx_done on final timeout cycle -> req_done, not req_err.
- Reset mid-operation: rst_n=0 for 1 cycle during WAIT_DONE -> next cycle all outputs 0, state IDLE, no done/err; rr pointer back to 0 (req=1111 grants requester 0 first).
